button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front end for the board cursor/placement logic on the VGA battleship board.
- Takes the five raw, bouncing, asynchronous push-button inputs (four directions plus place).
- Produces clean, single-cycle, active-low command pulses: move_up, move_down, move_left, move_right, place.
- The cursor-movement stage consumes these directly. It treats a level of 0 as "move this cycle", so each press must appear as exactly one low cycle.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles an input must stay stable before its debounced state changes (10 ms at 50 MHz). Legal range is 2 or more. The counter width is derived internally as clog2(DEBOUNCE_CYCLES).
- REPEAT_DELAY, 25000000: cycles from the first pulse to the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- btn_up_n  in  1  raw up button, 0 = pressed, asynchronous
- btn_down_n  in  1  raw down button, 0 = pressed
- btn_left_n  in  1  raw left button, 0 = pressed
- btn_right_n  in  1  raw right button, 0 = pressed
- btn_place_n  in  1  raw place button, 0 = pressed
- move_up  out  1  one-cycle low pulse per accepted up press
- move_down  out  1  one-cycle low pulse per accepted down press
- move_left  out  1  one-cycle low pulse per accepted left press
- move_right  out  1  one-cycle low pulse per accepted right press
- place  out  1  one-cycle low pulse per accepted place press

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchronizer flops, debounced-state registers and outputs go to 1.
  - All counters go to 0.
  - Every output is 1 (idle) throughout reset.
- Synchronizer: each button passes through a 2-flop synchronizer (s1, s2) before any other use.
- Debounce, per button, independent:
  - Registers: stable (reset 1) and cnt.
  - If s2 == stable, cnt <= 0.
  - Otherwise, cnt increments each cycle.
  - At an edge where s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
- Pulse generation:
  - A raw pulse is asserted at the same edge where stable goes 1->0 (press).
  - A 0->1 transition (release) produces no pulse.
- Latency: if raw input is low at sampling edge E0 and held, the output is low for exactly the one cycle following edge E0+DEBOUNCE_CYCLES+1.
- Glitch rejection: a low glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles produces no pulse, and cnt returns to 0.
- Release bounce: bounce during release never creates a second pulse. A new press pulse requires stable to have returned to 1 first.
- Direction exclusivity:
  - At most one of move_up/down/left/right is low in any cycle.
  - If several direction pulses would fire in the same cycle, priority is up > down > left > right.
  - Losing pulses are dropped, not queued.
- place is independent of the direction priority and may coincide with a direction pulse.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-operation: counters and pulses are cleared immediately. A button still held when rst releases is treated as a fresh press and pulses DEBOUNCE_CYCLES+1 edges after its first low sample following reset.
- Held button (feature off): exactly one pulse per press, regardless of hold length.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - Each direction button (not place) gets a repeat counter.
  - While its stable is 0, a further pulse fires REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - Repeat pulses pass through the same priority arbitration.
  - The repeat counter clears when stable returns to 1 and on reset.
- When undefined: no repeat logic is instantiated, and behaviour is one pulse per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Clean press: btn_up_n low at edge 0, held 20 cycles -> move_up=0 only during the cycle after edge 5; all other outputs stay 1.
- Glitch rejection: btn_left_n low for 3 cycles, then high -> no pulse on any output; internal cnt returns to 0.
- Bounce: btn_down_n toggles low/high every cycle for 6 cycles, then held low -> exactly one move_down pulse, 5 edges after the final low begins. Release bounce -> no pulse.
- Priority: btn_up_n and btn_right_n fall at the same edge -> move_up pulses once, move_right never pulses. btn_place_n at the same edge also -> place pulses in the same cycle as move_up.
- Reset mid-count: btn_right_n low, rst pulsed low at cnt=2 with button held, rst released at edge R -> no pulse during reset; move_right pulse in the cycle after edge R+5.
- AUTO_REPEAT_EN defined: btn_up_n held 30 cycles -> move_up pulses after edges 5, 13, 17, 21, 25, 29; released -> pulses stop; place held -> single pulse only.

Source files
------------

// File: rtl/button_conditioner.sv
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronises, debounces and edge-detects five raw push-buttons
//             into one-cycle active-low command pulses. The four direction
//             pulses are mutually exclusive. Optional macro AUTO_REPEAT_EN
//             adds hold-to-repeat on the direction buttons.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_n,
    input  logic btn_down_n,
    input  logic btn_left_n,
    input  logic btn_right_n,
    input  logic btn_place_n,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic place
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: illegal parameter value");
    end

    // Bit order everywhere: 0 up, 1 down, 2 left, 3 right, 4 place
    logic [4:0] w_btn_n;
    logic [4:0] w_press;
    logic [4:0] w_fire;
    logic [3:0] w_dir_grant;
    logic [4:0] r_out;

    assign w_btn_n = {btn_place_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic               r_s1;
        logic               r_s2;
        logic               r_stable;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_s1     <= 1'b1;
                r_s2     <= 1'b1;
                r_stable <= 1'b1;
                r_cnt    <= '0;
            end else begin
                r_s1 <= w_btn_n[i];
                r_s2 <= r_s1;
                if (r_s2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Press is the edge at which stable is about to fall
        assign w_press[i] = r_stable & ~r_s2 & (r_cnt == c_DB_LAST);

`ifdef AUTO_REPEAT_EN
        if (i < 4) begin : g_rep
            localparam int c_REP_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ?
                                            REPEAT_DELAY : REPEAT_PERIOD) + 1;
            localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
            localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

            logic [c_REP_W-1:0] r_rcnt;
            logic               r_first;
            logic               w_rep;

            // First repeat waits the long delay, later ones the short period
            assign w_rep = ~r_stable &
                           (r_rcnt == (r_first ? c_DELAY_LAST : c_PERIOD_LAST));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rcnt  <= '0;
                    r_first <= 1'b1;
                end else if (r_stable) begin
                    r_rcnt  <= '0;
                    r_first <= 1'b1;
                end else if (w_rep) begin
                    r_rcnt  <= '0;
                    r_first <= 1'b0;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end

            assign w_fire[i] = w_press[i] | w_rep;
        end else begin : g_no_rep
            assign w_fire[i] = w_press[i];
        end
`else
        assign w_fire[i] = w_press[i];
`endif
    end

    // Fixed priority up > down > left > right; losers are dropped
    always_comb begin
        w_dir_grant = 4'b0000;
        if (w_fire[0])      w_dir_grant = 4'b0001;
        else if (w_fire[1]) w_dir_grant = 4'b0010;
        else if (w_fire[2]) w_dir_grant = 4'b0100;
        else if (w_fire[3]) w_dir_grant = 4'b1000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= 5'b11111;
        end else begin
            r_out <= ~{w_fire[4], w_dir_grant};
        end
    end

    assign move_up    = r_out[0];
    assign move_down  = r_out[1];
    assign move_left  = r_out[2];
    assign move_right = r_out[3];
    assign place      = r_out[4];

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Directed self-checking bench for button_conditioner
//             (DEBOUNCE_CYCLES=4, default build without auto-repeat).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up_n    = 1'b1;
    logic btn_down_n  = 1'b1;
    logic btn_left_n  = 1'b1;
    logic btn_right_n = 1'b1;
    logic btn_place_n = 1'b1;
    logic move_up, move_down, move_left, move_right, place;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .btn_left_n (btn_left_n),
        .btn_right_n(btn_right_n),
        .btn_place_n(btn_place_n),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .place      (place)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int edge_n    = -1;
    int excl_viol = 0;
    int low_cnt   [5];
    int first_low [5];

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edge numbering restarts so that the next rising edge is edge 0
    task automatic clear_stats();
        edge_n = -1;
        for (int i = 0; i < 5; i++) begin
            low_cnt[i]   = 0;
            first_low[i] = -1;
        end
    endtask

    task automatic step();
        logic [4:0] o;
        int         nd;
        @(posedge clk);
        #1;
        edge_n++;
        o  = {place, move_right, move_left, move_down, move_up};
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            if (!o[i]) begin
                low_cnt[i]++;
                if (first_low[i] < 0) first_low[i] = edge_n;
                if (i < 4) nd++;
            end
        end
        if (nd > 1) excl_viol++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic release_all();
        btn_up_n    = 1'b1;
        btn_down_n  = 1'b1;
        btn_left_n  = 1'b1;
        btn_right_n = 1'b1;
        btn_place_n = 1'b1;
        steps(15);
        clear_stats();
    endtask

    initial begin
        clear_stats();

        // Reset held: all outputs idle high
        steps(3);
        check_eq("reset_up",    int'(move_up),    1);
        check_eq("reset_down",  int'(move_down),  1);
        check_eq("reset_left",  int'(move_left),  1);
        check_eq("reset_right", int'(move_right), 1);
        check_eq("reset_place", int'(place),      1);
        rst = 1'b1;
        steps(3);
        clear_stats();

        // Clean press, held 20 cycles: one pulse after edge 5
        btn_up_n = 1'b0;
        steps(20);
        check_eq("clean_up_edge",  first_low[0], 5);
        check_eq("clean_up_count", low_cnt[0],   1);
        check_eq("clean_others",   low_cnt[1] + low_cnt[2] + low_cnt[3] + low_cnt[4], 0);
        btn_up_n = 1'b1;
        steps(12);
        check_eq("release_no_pulse", low_cnt[0], 1);
        release_all();

        // Glitch of 3 cycles rejected; a later real press still takes full latency
        btn_left_n = 1'b0;
        steps(3);
        btn_left_n = 1'b1;
        steps(10);
        check_eq("glitch_no_pulse", low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3] + low_cnt[4], 0);
        btn_left_n = 1'b0;
        clear_stats();
        steps(12);
        check_eq("post_glitch_edge",  first_low[2], 5);
        check_eq("post_glitch_count", low_cnt[2],   1);
        release_all();

        // Press bounce: low/high for 6 cycles, then held low from edge 6
        for (int k = 0; k < 6; k++) begin
            btn_down_n = (k % 2 == 1);
            step();
        end
        btn_down_n = 1'b0;
        steps(20);
        check_eq("bounce_down_edge",  first_low[1], 11);
        check_eq("bounce_down_count", low_cnt[1],   1);
        // Release bounce must not retrigger
        for (int k = 0; k < 6; k++) begin
            btn_down_n = (k % 2 == 0);
            step();
        end
        btn_down_n = 1'b1;
        steps(15);
        check_eq("release_bounce_count", low_cnt[1], 1);
        release_all();

        // Priority: up beats right, place coincides with up
        btn_up_n    = 1'b0;
        btn_right_n = 1'b0;
        btn_place_n = 1'b0;
        steps(12);
        check_eq("prio_up_edge",     first_low[0], 5);
        check_eq("prio_up_count",    low_cnt[0],   1);
        check_eq("prio_right_count", low_cnt[3],   0);
        check_eq("prio_place_edge",  first_low[4], 5);
        check_eq("prio_place_count", low_cnt[4],   1);
        release_all();

        // Priority: down beats left
        btn_down_n = 1'b0;
        btn_left_n = 1'b0;
        steps(12);
        check_eq("prio_down_edge",  first_low[1], 5);
        check_eq("prio_left_count", low_cnt[2],   0);
        release_all();

        // Priority: left beats right
        btn_left_n  = 1'b0;
        btn_right_n = 1'b0;
        steps(12);
        check_eq("prio_left_edge",   first_low[2], 5);
        check_eq("prio_right2_count", low_cnt[3],  0);
        release_all();

        // Reset mid-count with the button still held
        btn_right_n = 1'b0;
        steps(4);
        rst = 1'b0;
        steps(4);
        check_eq("rst_mid_no_pulse", low_cnt[3], 0);
        check_eq("rst_mid_idle",     int'(move_right), 1);
        rst = 1'b1;
        clear_stats();
        steps(12);
        check_eq("rst_mid_edge",  first_low[3], 5);
        check_eq("rst_mid_count", low_cnt[3],   1);
        release_all();

        check_eq("dir_exclusive", excl_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
